// File: rtl/sram_a_1kx8_if.sv
// sram_a_1kx8_if: address/data/write-enable bus of the A-operand SRAM.
interface sram_a_1kx8_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              sram_A_we;
    logic [ADDR_W-1:0] sram_A_addr;
    logic [DATA_W-1:0] sram_A_din;
    logic [DATA_W-1:0] sram_A_dout;

    modport master (output sram_A_we, sram_A_addr, sram_A_din, input sram_A_dout);
    modport slave  (input sram_A_we, sram_A_addr, sram_A_din, output sram_A_dout);
endinterface

// File: rtl/sram_a_1kx8.sv
// sram_a_1kx8: single-port write-first SRAM with registered read data (NPU A-operand buffer).
module sram_a_1kx8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input logic          rpll_clk,
    input logic          rst_n,
    sram_a_1kx8_if.slave sram_a
);
    localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              w_in_range;
    logic              w_wr;

    assign w_in_range = ({1'b0, sram_a.sram_A_addr} < LP_DEPTH);
    assign w_wr       = rst_n && sram_a.sram_A_we && w_in_range;

    // Array has no reset so it maps onto block RAM; reset only gates writes.
    always_ff @(posedge rpll_clk) begin
        if (w_wr) r_mem[sram_a.sram_A_addr] <= sram_a.sram_A_din;
    end

    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n)
            r_dout <= '0;
        else if (sram_a.sram_A_we)
            r_dout <= sram_a.sram_A_din;
        else
            r_dout <= w_in_range ? r_mem[sram_a.sram_A_addr] : '0;
    end

    assign sram_a.sram_A_dout = r_dout;
endmodule

// File: tb/tb_sram_a_1kx8.sv
// tb_sram_a_1kx8: directed and random checks of the A-operand SRAM.
`timescale 1ns/1ps
module tb_sram_a_1kx8;
    logic rpll_clk = 1'b0;
    logic rst_n    = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    sram_a_1kx8_if #(.DATA_W(8), .ADDR_W(10)) bus ();

    sram_a_1kx8 dut (
        .rpll_clk (rpll_clk),
        .rst_n    (rst_n),
        .sram_a   (bus.slave)
    );

    always #10.582 rpll_clk = ~rpll_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        bus.sram_A_we   = 1'b1;
        bus.sram_A_addr = a;
        bus.sram_A_din  = d;
        @(negedge rpll_clk);
        bus.sram_A_we   = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [7:0] exp, input string tag);
        bus.sram_A_we   = 1'b0;
        bus.sram_A_addr = a;
        @(negedge rpll_clk);
        check(tag, bus.sram_A_dout, exp);
    endtask

    initial begin
        logic [9:0] ra;
        logic [7:0] rdat;
        bus.sram_A_we   = 1'b0;
        bus.sram_A_addr = '0;
        bus.sram_A_din  = '0;
        repeat (2) @(negedge rpll_clk);
        check("reset_state", bus.sram_A_dout, 8'h00);
        rst_n = 1'b1;
        wr(10'd5, 8'h3C);
        check("wf_3c", bus.sram_A_dout, 8'h3C);
        wr(10'd6, 8'hA5);
        check("wf_a5", bus.sram_A_dout, 8'hA5);
        bus.sram_A_addr = 10'd6;
        @(posedge rpll_clk);
        #4;
        check("pre_reset_a5", bus.sram_A_dout, 8'hA5);
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.sram_A_dout, 8'h00);
        bus.sram_A_we   = 1'b1;
        bus.sram_A_addr = 10'd5;
        bus.sram_A_din  = 8'h99;
        repeat (2) @(negedge rpll_clk);
        check("reset_hold", bus.sram_A_dout, 8'h00);
        bus.sram_A_we = 1'b0;
        rst_n = 1'b1;
        rd(10'd5, 8'h3C, "preserved_3c");
        wr(10'd0, 8'h5A);
        wr(10'd1023, 8'hC3);
        rd(10'd0, 8'h5A, "rd_addr0");
        rd(10'd1023, 8'hC3, "rd_addr1023");
        wr(10'd512, 8'h7E);
        check("wf_7e", bus.sram_A_dout, 8'h7E);
        rd(10'd512, 8'h7E, "hold_7e_1");
        rd(10'd512, 8'h7E, "hold_7e_2");
        wr(10'd300, 8'h11);
        wr(10'd300, 8'h22);
        rd(10'd300, 8'h22, "overwrite");
        wr(10'd10, 8'hFF);
        wr(10'd11, 8'h00);
        rd(10'd10, 8'hFF, "indep_10");
        rd(10'd11, 8'h00, "indep_11");
        rd(10'd6, 8'hA5, "blocked_neighbour");
        for (int i = 0; i < 1000; i++) begin
            ra   = 10'($urandom_range(0, 1023));
            rdat = 8'($urandom);
            wr(ra, rdat);
            check("rand_wr1", bus.sram_A_dout, rdat);
            wr(ra, rdat);
            check("rand_wr2", bus.sram_A_dout, rdat);
            rd(ra, rdat, "rand_rd1");
            rd(ra, rdat, "rand_rd2");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_a_1kx8.md
Name: sram_a_1kx8

Overview:
- Single-port synchronous SRAM: 1024 words x 8 bits, one shared address bus, write enable, registered read data.
- Serves as the "A" operand buffer of the NPU datapath.
- Clocked from the rPLL output domain (47.25 MHz nominal, 21.164 ns period).
- Maps onto one FPGA block RAM configured in write-first mode, with an output register.

Parameters:
- DATA_W, 8, width of each memory word and of sram_A_din / sram_A_dout.
- ADDR_W, 10, width of sram_A_addr.
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- rpll_clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears the read-data register only.
- sram_A_we  input  1  write enable; 1 = write sram_A_din to sram_A_addr on this rising edge.
- sram_A_addr  input  ADDR_W  word address for both read and write.
- sram_A_din  input  DATA_W  write data.
- sram_A_dout  output  DATA_W  registered read data.

Behaviour:
- Reset:
  - rst_n low forces sram_A_dout to 0 immediately (asynchronous), independent of rpll_clk.
  - While rst_n is low, writes are blocked.
  - Memory array contents are not altered by reset.
  - Release is synchronous in effect: the first rising edge with rst_n high performs a normal access.
- Power-up contents of the array are 0 (initialised at configuration).
- Write:
  - On a rising edge with rst_n=1 and sram_A_we=1, mem[sram_A_addr] <= sram_A_din.
  - Single-cycle; no handshake, no busy state.
- Read:
  - On every rising edge with rst_n=1 and sram_A_we=0, sram_A_dout <= mem[sram_A_addr].
  - Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N.
- Write-first: on a write edge, sram_A_dout <= sram_A_din, so new data appears on the output in the same cycle as the write.
- sram_A_dout holds its value between edges. It changes only on rising edges (or on reset assertion).
- Back-to-back accesses:
  - A read on the edge immediately after a write to the same address returns the newly written data.
  - There is no hazard window.
- Address range:
  - When DEPTH = 2**ADDR_W, every address is valid and there is no wrap logic.
  - When DEPTH < 2**ADDR_W and addr >= DEPTH, writes are ignored and a read loads 0 into sram_A_dout.
- Inputs are sampled only at rising edges. Stimulus changing at the falling edge must be fully supported.
- No combinational path from any input to sram_A_dout, except the asynchronous reset.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle after loading sram_A_dout=8'hA5.
  - Required: sram_A_dout=0 immediately, without waiting for an edge.
  - Stimulus: release rst_n, then read an address previously written with 8'h3C.
  - Required: returns 8'h3C (contents preserved).
- Write/read:
  - Stimulus: write 8'h5A to addr 0 and 8'hC3 to addr 1023, with we=0 afterwards; read each.
  - Required: sram_A_dout=8'h5A and 8'hC3 respectively, 1 cycle after the address is presented.
- Write-first:
  - Stimulus: write 8'h7E to addr 512.
  - Required: sram_A_dout=8'h7E after that same write edge.
  - Stimulus: then hold addr with we=0 for 2 cycles.
  - Required: sram_A_dout stays 8'h7E.
- Overwrite: write 8'h11 then 8'h22 to addr 300 on consecutive edges; read -> 8'h22.
- Independence: write 8'hFF to addr 10, then 8'h00 to addr 11; read addr 10 -> 8'hFF.
- Random: 1000 iterations, each of:
  - Drive a random addr 0..1023 and random data at the falling edge, with we=1 for 2 cycles, then we=0 for 2 cycles.
  - Required: sram_A_dout equals the written data in all 1000 iterations.
